data_mem_dp: RTL and testbench

Parametrised simple-dual-port data memory: one write port with byte strobes and one registered read port with a valid flag. A built-in clear engine zeroes the array after reset and on request. It replaces the fixed 8-bit/256-entry data memory behind the datapath's load/store stage and adds configurable width and depth, independent read and write addresses, read-during-write selection and hardware clear.

---
 rtl/data_mem_pkg.sv | 27 ++
 rtl/data_mem_array.sv | 49 ++++
 rtl/data_mem_dp.sv | 144 ++++++++++++++
 tb/tb_data_mem_dp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared types and helpers for the dual-port data memory.
//                - state_t     : controller state (IDLE / CLEAR)
//                - bytes_of    : number of byte lanes in a word
//                - data_w_ok   : word-width legality check used at elaboration
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction

   // Byte strobes only make sense for whole bytes.
   function automatic bit data_w_ok(input int data_w);
      return (data_w > 0) && ((data_w % 8) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : Storage array with one byte-strobed synchronous write port
//                and one combinational (unregistered) read port. No reset on
//                the contents; zeroing is done by the owner via the write port.
//  Ports       : clk      - clock
//                wr_en    - write enable
//                wr_addr  - write address
//                wr_data  - write data
//                wr_strb  - byte enables, bit k gates wr_data[8k+7:8k]
//                rd_addr  - read address
//                rd_word  - current contents of mem[rd_addr]
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [bytes_of(DATA_W)-1:0]   wr_strb,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_word
);

   localparam int BYTES = bytes_of(DATA_W);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) begin
               mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_word = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_dp.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dp
//  Description : Simple-dual-port data memory with byte-strobed writes, a
//                registered read port with valid pulse, selectable
//                read-during-write behaviour and a hardware clear engine that
//                zeroes the whole array after reset and on request.
//  Ports       : clk      - clock (rising edge)
//                rst      - asynchronous active-high reset
//                wr_en    - write request
//                wr_addr  - write address
//                wr_data  - write data
//                wr_strb  - byte enables
//                rd_en    - read request
//                rd_addr  - read address
//                rd_data  - registered read data
//                rd_valid - one-cycle pulse, rd_data holds a new result
//                clr_req  - start a full-array clear
//                busy     - clear in progress, read/write ports ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_dp
   import data_mem_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter bit WRITE_FIRST = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [bytes_of(DATA_W)-1:0]   wr_strb,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_valid,
   input  logic                          clr_req,
   output logic                          busy
);

   localparam int BYTES = bytes_of(DATA_W);

   generate
      if (!data_w_ok(DATA_W)) begin : g_bad_data_w
         $error("data_mem_dp: DATA_W must be a non-zero multiple of 8");
      end
   endgenerate

   state_t              state;
   logic [ADDR_W-1:0]   clr_cnt;

   logic                clearing;
   logic                wr_act;
   logic                rd_act;
   logic                rdw_hit;
   logic                arr_wr_en;
   logic [ADDR_W-1:0]   arr_wr_addr;
   logic [DATA_W-1:0]   arr_wr_data;
   logic [BYTES-1:0]    arr_wr_strb;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   merged;
   logic [DATA_W-1:0]   rd_next;

   // clr_req wins over any same-cycle access, so both ports are gated by it.
   assign clearing = (state == CLEAR);
   assign wr_act   = (state == IDLE) && !clr_req && wr_en;
   assign rd_act   = (state == IDLE) && !clr_req && rd_en;

   // Clear engine borrows the write port with every byte lane enabled.
   assign arr_wr_en   = clearing || wr_act;
   assign arr_wr_addr = clearing ? clr_cnt : wr_addr;
   assign arr_wr_data = clearing ? '0      : wr_data;
   assign arr_wr_strb = clearing ? '1      : wr_strb;

   data_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_wr_en),
      .wr_addr (arr_wr_addr),
      .wr_data (arr_wr_data),
      .wr_strb (arr_wr_strb),
      .rd_addr (rd_addr),
      .rd_word (rd_word)
   );

   // Word as it will look after this cycle's write: strobed bytes new,
   // the rest from the array. Only meaningful when addresses match.
   always_comb begin
      merged = rd_word;
      for (int b = 0; b < BYTES; b++) begin
         if (wr_strb[b]) begin
            merged[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   assign rdw_hit = wr_act && (wr_addr == rd_addr);
   assign rd_next = (WRITE_FIRST && rdw_hit) ? merged : rd_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         busy     <= 1'b1;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               rd_valid <= rd_act;
               if (rd_act) begin
                  rd_data <= rd_next;
               end
               if (clr_req) begin
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  clr_cnt <= '0;
               end
            end
            CLEAR: begin
               rd_valid <= 1'b0;
               // Wraps to zero on the final address, ready for the next clear.
               clr_cnt  <= clr_cnt + 1'b1;
               if (&clr_cnt) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= CLEAR;
               busy     <= 1'b1;
               clr_cnt  <= '0;
               rd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_dp
//  Description : Scoreboard bench for data_mem_dp. Two instances (old-data and
//                new-data read-during-write) share one stimulus stream; a
//                behavioural memory model predicts every read result and the
//                busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_dp;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en, clr_req;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_strb;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1, busy0, busy1;

   always #5 clk = ~clk;

   data_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .WRITE_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .clr_req(clr_req), .busy(busy0));

   data_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .WRITE_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1));

   // ---------------- reference model ----------------
   logic [DW-1:0] mem_m [DEPTH];
   int            clr_left;          // zero-writes still to be performed
   logic [DW-1:0] last0, last1;      // value rd_data should be holding
   logic [DW-1:0] q0[$], q1[$];      // expected read results

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rd_valid0) begin
         if (q0.size() == 0) chk("dut0 unexpected rd_valid", 32'd1, 32'd0);
         else chk("dut0 rd_data", rd_data0, q0.pop_front());
      end
      if (rd_valid1) begin
         if (q1.size() == 0) chk("dut1 unexpected rd_valid", 32'd1, 32'd0);
         else chk("dut1 rd_data", rd_data1, q1.pop_front());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic quiet();
      wr_en = 0; rd_en = 0; clr_req = 0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
   endtask

   // Apply current inputs for one edge, predicting the outcome from the rules.
   task automatic step();
      logic [DW-1:0] old_w, new_w;
      old_w = mem_m[rd_addr];
      if (clr_left != 0) begin
         mem_m[DEPTH - clr_left] = '0;
         clr_left--;
      end else if (clr_req) begin
         clr_left = DEPTH;
      end else begin
         new_w = mem_m[wr_addr];
         for (int k = 0; k < 4; k++)
            if (wr_strb[k]) new_w[8*k +: 8] = wr_data[8*k +: 8];
         if (rd_en) begin
            last0 = old_w;
            last1 = (wr_en && wr_addr == rd_addr) ? new_w : old_w;
            q0.push_back(last0);
            q1.push_back(last1);
         end
         if (wr_en) mem_m[wr_addr] = new_w;
      end
      @(posedge clk);
      #1;
      chk("dut0 busy", {31'd0, busy0}, {31'd0, clr_left != 0});
      chk("dut1 busy", {31'd0, busy1}, {31'd0, clr_left != 0});
      chk("dut0 rd_data hold", rd_data0, last0);
      chk("dut1 rd_data hold", rd_data1, last1);
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      quiet(); wr_en = 1; wr_addr = a; wr_data = d; wr_strb = s; step();
   endtask

   task automatic read(input logic [AW-1:0] a);
      quiet(); rd_en = 1; rd_addr = a; step();
   endtask

   // Asynchronous reset applied between edges; outputs must drop at once.
   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst rd_valid0", {31'd0, rd_valid0}, 32'd0);
      chk("rst rd_data0", rd_data0, 32'd0);
      chk("rst rd_valid1", {31'd0, rd_valid1}, 32'd0);
      chk("rst rd_data1", rd_data1, 32'd0);
      chk("rst busy0", {31'd0, busy0}, 32'd1);
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      clr_left = DEPTH;
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;
      quiet();
      rst = 1;
      clr_left = DEPTH;
      last0 = '0; last1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy0}, 32'd1);
      chk("reset rd_valid", {31'd0, rd_valid0}, 32'd0);
      chk("reset rd_data", rd_data0, 32'd0);
      rst = 0;

      // Initial clear: port requests during it must be ignored.
      for (int i = 0; i < DEPTH; i++) begin
         quiet();
         rd_en = $urandom_range(0, 1); rd_addr = $urandom;
         wr_en = $urandom_range(0, 1); wr_addr = $urandom; wr_data = $urandom;
         wr_strb = $urandom; clr_req = (i == 50);
         step();
      end

      read(8'h00); read(8'h7F); read(8'hFF);

      // Full write then read back, and byte-strobed overwrite.
      write(8'h10, 32'hDEADBEEF, 4'b1111);
      read(8'h10);
      write(8'h10, 32'h11223344, 4'b0101);
      read(8'h10);
      chk("strobe model", mem_m[8'h10], 32'hDE22BE44);
      write(8'h11, 32'hFFFFFFFF, 4'b0000);
      read(8'h11);

      // Read-during-write, full and partial strobes.
      write(8'h20, 32'h000000AA, 4'b1111);
      quiet(); wr_en = 1; wr_addr = 8'h20; wr_data = 32'h00000055; wr_strb = 4'b1111;
      rd_en = 1; rd_addr = 8'h20; step();
      quiet(); wr_en = 1; wr_addr = 8'h20; wr_data = 32'hCAFE0000; wr_strb = 4'b1100;
      rd_en = 1; rd_addr = 8'h20; step();
      // Different addresses: no interaction.
      quiet(); wr_en = 1; wr_addr = 8'h21; wr_data = 32'h12345678; wr_strb = 4'b1111;
      rd_en = 1; rd_addr = 8'h20; step();
      read(8'h21);

      // Clear request with a same-cycle write that must be dropped.
      write(8'h05, 32'h00000011, 4'b1111);
      quiet(); clr_req = 1; wr_en = 1; wr_addr = 8'h05; wr_data = 32'h77; wr_strb = 4'b1111;
      rd_en = 1; rd_addr = 8'h05; step();
      for (int i = 0; i < DEPTH; i++) begin
         quiet(); clr_req = (i == 128); rd_en = 1; rd_addr = 8'h05;
         step();
      end
      read(8'h05); read(8'h10);

      // Randomised traffic over a small address window to provoke collisions.
      for (int i = 0; i < 400; i++) begin
         quiet();
         wr_en   = ($urandom_range(0, 2) != 0);
         wr_addr = 8'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_strb = 4'($urandom);
         rd_en   = ($urandom_range(0, 2) != 0);
         rd_addr = 8'($urandom_range(0, 15));
         clr_req = ($urandom_range(0, 199) == 0);
         step();
      end
      quiet();
      while (clr_left != 0) step();

      // Back-to-back reads, then reset while a result is presented.
      write(8'h30, 32'hA5A5A5A5, 4'b1111);
      read(8'h30); read(8'h30);
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin quiet(); step(); end

      // Reset in the middle of a clear restarts it from address 0.
      quiet(); clr_req = 1; step();
      for (int i = 0; i < 100; i++) begin quiet(); rd_en = 1; step(); end
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin quiet(); rd_en = 1; step(); end
      read(8'h30); read(8'h63);

      quiet(); step(); step();
      chk("dut0 pending reads", 32'(q0.size()), 32'd0);
      chk("dut1 pending reads", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
